sqrt_seq: RTL

//  Sequential, width-parametrised integer square root: O = floor(sqrt(I)) or round-to-nearest,

---
 rtl/sqrt_pkg.sv | 14 +
 rtl/sqrt_step.sv | 25 ++
 rtl/sqrt_seq.sv | 101 ++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared FSM encoding and root-width helper for the sequential square root
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int root_width(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one restoring digit step, producing the next root bit and partial remainder
module sqrt_step #(
    parameter int N = 4
) (
    input  logic [N:0]   rem,
    input  logic [N-1:0] root,
    input  logic [1:0]   pair,
    output logic [N:0]   rem_n,
    output logic [N-1:0] root_n,
    output logic         root_bit
);

    logic [N+1:0] a;
    logic [N+2:0] d;

    // trial-subtract 4*root+1 from the shifted remainder; keep it only when non-negative
    always_comb begin
        a        = (N+2)'({rem, pair});
        d        = {1'b0, a} - {1'b0, root, 2'b01};
        root_bit = ~d[N+2];
        rem_n    = root_bit ? (N+1)'(d) : (N+1)'(a);
        root_n   = N'({root, root_bit});
    end

endmodule

// File: rtl/sqrt_seq.sv
// sqrt_seq: sequential integer square root, one root bit per cycle, valid/ready handshakes
module sqrt_seq
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ROUND = 0,
    localparam int N    = root_width(WIDTH),
    localparam int CW   = N > 1 ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     o,
    output logic [N:0]       rem,
    output logic             exact
);

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh;
    logic [N:0]       acc;
    logic [N-1:0]     root;
    logic [N:0]       rem_n;
    logic [N-1:0]     root_n;
    logic             root_bit;
    logic             up;
    logic [N-1:0]     o_n;

    sqrt_step #(.N(N)) u_step (
        .rem      (acc),
        .root     (root),
        .pair     (sh[WIDTH-1:WIDTH-2]),
        .rem_n    (rem_n),
        .root_n   (root_n),
        .root_bit (root_bit)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next state and handshake outputs; a new radicand is only taken once the result is gone
    always_comb begin
        state_n   = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        case (state)
            IDLE:    state_n = in_valid ? CALC : IDLE;
            CALC:    state_n = cnt == '0 ? DONE : CALC;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // nearest-root adjustment from the final step, saturating instead of wrapping
    always_comb begin
        up  = ROUND != 0 && !(&root_n) && {1'b0, root_n} < rem_n;
        o_n = root_n + N'(up);
    end

    // datapath: load on accept, iterate in CALC, publish result on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sh    <= '0;
            acc   <= '0;
            root  <= '0;
            o     <= '0;
            rem   <= '0;
            exact <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sh   <= i;
                    acc  <= '0;
                    root <= '0;
                    cnt  <= CW'(N - 1);
                end
                CALC: begin
                    sh   <= sh << 2;
                    acc  <= rem_n;
                    root <= root_n;
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0) begin
                        o     <= o_n;
                        rem   <= rem_n;
                        exact <= rem_n == '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
